// File: rtl/map_hit_arbiter.sv
// Round-robin arbiter serialising bullet damage requests onto the tile store RMW port.
// Optional BRICK_TO_AIR_EN: a fully cleared brick is written back as AIR instead of an empty brick.
//
// state | meaning
// IDLE  | arbitrate, accept one request, latch tile and mask
// READ  | drive tile address, store returns word next cycle
// EVAL  | apply mask to returned word, decide outcome
// WRITE | one-cycle write strobe of the updated word
// DONE  | completion pulse and result to the owner
module map_hit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int MAP_DIM = 13
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [4*NUM_REQ-1:0] req_x_i,
  input  logic [4*NUM_REQ-1:0] req_y_i,
  input  logic [4*NUM_REQ-1:0] req_mask_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic [NUM_REQ-1:0]   done_o,
  output logic [1:0]           result_o,
  output logic                 busy_o,
  output logic [3:0]           map_x_o,
  output logic [3:0]           map_y_o,
  input  logic [6:0]           map_rd_data_i,
  output logic                 map_we_o,
  output logic [6:0]           map_wr_data_o
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [4:0] DIM = 5'(MAP_DIM);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_EVAL, S_WRITE, S_DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] ptr, owner, grant_idx, cand;
  logic          grant_found;
  logic [3:0]    sel_x, sel_y, sel_mask;
  logic          sel_in_range;
  logic [3:0]    lat_x, lat_y, lat_mask;
  logic          in_range;
  logic [1:0]    result;
  logic [6:0]    wr_word;
  logic [2:0]    rd_type;
  logic [3:0]    rd_state, hit, remain;
  logic [1:0]    eval_result;
  logic          eval_write;
  logic [6:0]    eval_word;

  // Search starts at ptr, which always holds last_grant+1 modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign sel_x        = req_x_i[{grant_idx, 2'b00} +: 4];
  assign sel_y        = req_y_i[{grant_idx, 2'b00} +: 4];
  assign sel_mask     = req_mask_i[{grant_idx, 2'b00} +: 4];
  assign sel_in_range = ({1'b0, sel_x} < DIM) && ({1'b0, sel_y} < DIM);

  assign rd_type  = map_rd_data_i[6:4];
  assign rd_state = map_rd_data_i[3:0];
  assign hit      = rd_state & lat_mask;
  assign remain   = rd_state & ~lat_mask;

  always_comb begin
    eval_result = 2'b00;
    eval_write  = 1'b0;
    eval_word   = {3'b000, remain};
    case (rd_type)
      3'b000: begin
        if (hit != 4'b0000) begin
          eval_write = 1'b1;
          if (remain != 4'b0000) begin
            eval_result = 2'b01;
          end else begin
            eval_result = 2'b10;
`ifdef BRICK_TO_AIR_EN
            eval_word = 7'b111_1111;
`else
            eval_word = 7'b000_0000;
`endif
          end
        end
      end
      3'b001:  eval_result = 2'b11;
      default: eval_result = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      ptr      <= '0;
      owner    <= '0;
      lat_x    <= '0;
      lat_y    <= '0;
      lat_mask <= '0;
      in_range <= 1'b0;
      result   <= 2'b00;
      wr_word  <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && grant_found) begin
        owner    <= grant_idx;
        lat_x    <= sel_x;
        lat_y    <= sel_y;
        lat_mask <= sel_mask;
        in_range <= sel_in_range;
        result   <= 2'b00;
        ptr      <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (state == S_EVAL) begin
        result  <= eval_result;
        wr_word <= eval_word;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant_found) state_nxt = sel_in_range ? S_READ : S_DONE;
      S_READ:  state_nxt = S_EVAL;
      S_EVAL:  state_nxt = eval_write ? S_WRITE : S_DONE;
      S_WRITE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are forced to their reset values while reset is high so an
  // in-flight write strobe or completion pulse is suppressed immediately.
  always_comb begin
    req_ready_o   = '0;
    done_o        = '0;
    result_o      = 2'b00;
    busy_o        = 1'b0;
    map_x_o       = 4'd0;
    map_y_o       = 4'd0;
    map_we_o      = 1'b0;
    map_wr_data_o = 7'd0;
    if (!reset_i) begin
      busy_o = (state != S_IDLE);
      if (state != S_IDLE && in_range) begin
        map_x_o = lat_x;
        map_y_o = lat_y;
      end
      case (state)
        S_IDLE:  if (grant_found) req_ready_o = NUM_REQ'(1) << grant_idx;
        S_WRITE: begin
          map_we_o      = 1'b1;
          map_wr_data_o = wr_word;
        end
        S_DONE: begin
          done_o   = NUM_REQ'(1) << owner;
          result_o = result;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_map_hit_arbiter.sv
// Self-checking bench for map_hit_arbiter: emulated tile store, timeline model and directed tests.
// Honours BRICK_TO_AIR_EN when the design is built with it.
module tb_map_hit_arbiter;
  localparam int N = 4;
  localparam int DIM = 13;

  logic           clk = 1'b0;
  logic           reset_i = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [4*N-1:0] req_x = '0, req_y = '0, req_mask = '0;
  logic [N-1:0]   req_ready, done;
  logic [1:0]     result;
  logic           busy;
  logic [3:0]     map_x, map_y;
  logic [6:0]     rd_data = 7'd0;
  logic           we;
  logic [6:0]     wr_data;

  always #5 clk = ~clk;

  map_hit_arbiter #(.NUM_REQ(N), .MAP_DIM(DIM)) dut (
    .clk_i(clk), .reset_i(reset_i), .req_valid_i(req_valid), .req_x_i(req_x),
    .req_y_i(req_y), .req_mask_i(req_mask), .req_ready_o(req_ready), .done_o(done),
    .result_o(result), .busy_o(busy), .map_x_o(map_x), .map_y_o(map_y),
    .map_rd_data_i(rd_data), .map_we_o(we), .map_wr_data_o(wr_data)
  );

  logic [6:0] tile_mem  [0:DIM-1][0:DIM-1];
  logic [6:0] model_mem [0:DIM-1][0:DIM-1];

  // Emulated tile store: registered read, write on strobe.
  always @(posedge clk) begin
    rd_data <= (map_x < DIM && map_y < DIM) ? tile_mem[map_y][map_x] : 7'd0;
    if (we && map_x < DIM && map_y < DIM) tile_mem[map_y][map_x] = wr_data;
  end

  int n_checks = 0, n_fail = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int onehot_idx(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Monitor logs
  int         cyc = 0, n_done = 0, n_we = 0, ready_cyc = 0, we_cyc = 0, done_cyc = 0;
  logic [6:0] we_data_log = '0;
  logic [1:0] res_log = '0;
  logic [N-1:0] done_log = '0, acc_mask = '0;
  int         grants[$];

  // Timeline model: one plan per accepted request, stepped by cycles since acceptance.
  int         m_ptr = 0, m_c = 0, m_g = 0, p_n = 0, p_owner = 0;
  bit         m_act = 0, p_inr = 0, p_wr = 0;
  logic [3:0] p_x, p_y, p_mask, p_st;
  logic [6:0] p_data, p_tile;
  logic [1:0] p_res;

  task automatic check_outs(logic [N-1:0] e_rdy, logic e_busy, logic [3:0] e_x, logic [3:0] e_y,
                            logic e_we, logic [6:0] e_wd, logic [N-1:0] e_done, logic [1:0] e_res);
    chk("ready", req_ready, e_rdy);
    chk("busy", busy, e_busy);
    chk("map_x", map_x, e_x);
    chk("map_y", map_y, e_y);
    chk("we", we, e_we);
    chk("wr_data", wr_data, e_wd);
    chk("done", done, e_done);
    chk("result", result, e_res);
  endtask

  task automatic make_plan(int g);
    p_owner = g;
    p_x = req_x[4*g +: 4];
    p_y = req_y[4*g +: 4];
    p_mask = req_mask[4*g +: 4];
    p_inr = (p_x < DIM) && (p_y < DIM);
    p_wr = 0; p_res = 2'b00; p_data = 7'd0;
    if (!p_inr) begin
      p_n = 1;
    end else begin
      p_n = 3;
      p_tile = model_mem[p_y][p_x];
      p_st = p_tile[3:0];
      if (p_tile[6:4] == 3'd0 && (p_st & p_mask) != 0) begin
        p_wr = 1; p_n = 4;
        if ((p_st & ~p_mask) != 0) begin
          p_res = 2'b01; p_data = {3'b000, p_st & ~p_mask};
        end else begin
          p_res = 2'b10;
`ifdef BRICK_TO_AIR_EN
          p_data = 7'h7F;
`else
          p_data = 7'h00;
`endif
        end
      end else if (p_tile[6:4] == 3'd1) begin
        p_res = 2'b11;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    acc_mask = req_valid & req_ready;
    if (req_ready != 0) begin ready_cyc = cyc; grants.push_back(onehot_idx(req_ready)); end
    if (we) begin n_we++; we_cyc = cyc; we_data_log = wr_data; end
    if (done != 0) begin n_done++; done_cyc = cyc; done_log = done; res_log = result; end

    if (reset_i) begin
      check_outs('0, 0, 0, 0, 0, 0, '0, 0);
      m_ptr = 0; m_act = 0;
    end else if (!m_act) begin
      m_g = -1;
      for (int i = 0; i < N; i++)
        if (m_g < 0 && req_valid[(m_ptr + i) % N]) m_g = (m_ptr + i) % N;
      check_outs((m_g >= 0) ? N'(1) << m_g : '0, 0, 0, 0, 0, 0, '0, 0);
      if (m_g >= 0) begin
        make_plan(m_g);
        m_ptr = (m_g + 1) % N; m_act = 1; m_c = 0;
      end
    end else begin
      m_c++;
      check_outs('0, 1, p_inr ? p_x : 4'd0, p_inr ? p_y : 4'd0,
                 p_wr && m_c == 3, (p_wr && m_c == 3) ? p_data : 7'd0,
                 (m_c == p_n) ? N'(1) << p_owner : '0, (m_c == p_n) ? p_res : 2'b00);
      if (p_wr && m_c == 3) model_mem[p_y][p_x] = p_data;
      if (m_c == p_n) m_act = 0;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~acc_mask;
  endtask

  task automatic set_req(int k, int x, int y, int m);
    req_x[4*k +: 4] = 4'(x);
    req_y[4*k +: 4] = 4'(y);
    req_mask[4*k +: 4] = 4'(m);
    req_valid[k] = 1'b1;
  endtask

  task automatic wait_done(int n, string name);
    int target;
    target = n_done + n;
    for (int i = 0; i < 80 && n_done < target; i++) tick();
    if (n_done < target) chk({name, "_timeout"}, n_done, target);
  endtask

  task automatic put_tile(int x, int y, logic [6:0] v);
    tile_mem[y][x] = v;
    model_mem[y][x] = v;
  endtask

  int nw0, nd0, gbase, mism;
  logic [6:0] destroyed;

  initial begin
`ifdef BRICK_TO_AIR_EN
    destroyed = 7'h7F;
`else
    destroyed = 7'h00;
`endif
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++) put_tile(x, y, 7'h7F);
    put_tile(3, 2, 7'h0F);
    put_tile(5, 5, 7'h06);
    put_tile(1, 1, 7'h1F);
    put_tile(2, 1, 7'h3F);
    put_tile(4, 4, 7'h0F); put_tile(6, 6, 7'h0F); put_tile(7, 7, 7'h0F); put_tile(8, 8, 7'h0F);
    put_tile(9, 9, 7'h0F);
    reset_i = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();

    // Single hit
    set_req(0, 3, 2, 4'b0001);
    wait_done(1, "t1");
    chk("t1_we_lat", we_cyc - ready_cyc, 3);
    chk("t1_done_lat", done_cyc - ready_cyc, 4);
    chk("t1_wdata", we_data_log, 7'h0E);
    chk("t1_res", res_log, 2'b01);
    chk("t1_owner", done_log, 4'b0001);
    chk("t1_store", tile_mem[2][3], 7'h0E);

    // Destroy, then hit the remains
    set_req(1, 5, 5, 4'b1111);
    wait_done(1, "t2");
    chk("t2_res", res_log, 2'b10);
    chk("t2_wdata", we_data_log, destroyed);
    chk("t2_store", tile_mem[5][5], destroyed);
    nw0 = n_we;
    set_req(1, 5, 5, 4'b0001);
    wait_done(1, "t2b");
    chk("t2b_res", res_log, 2'b00);
    chk("t2b_no_we", n_we - nw0, 0);

    // Wall and water
    nw0 = n_we;
    set_req(2, 1, 1, 4'b1111);
    wait_done(1, "t3");
    chk("t3_res", res_log, 2'b11);
    chk("t3_done_lat", done_cyc - ready_cyc, 3);
    set_req(3, 2, 1, 4'b1111);
    wait_done(1, "t3b");
    chk("t3b_res", res_log, 2'b00);
    chk("t3_no_we", n_we - nw0, 0);

    // Out of range
    nw0 = n_we;
    set_req(3, 13, 0, 4'b1111);
    wait_done(1, "t4");
    chk("t4_done_lat", done_cyc - ready_cyc, 1);
    chk("t4_res", res_log, 2'b00);
    chk("t4_owner", done_log, 4'b1000);
    chk("t4_no_we", n_we - nw0, 0);

    // Round robin from reset with all requesters pending
    reset_i = 1'b1;
    set_req(0, 4, 4, 4'b0001);
    set_req(1, 6, 6, 4'b0001);
    set_req(2, 7, 7, 4'b0001);
    set_req(3, 8, 8, 4'b0001);
    repeat (2) tick();
    gbase = grants.size();
    reset_i = 1'b0;
    wait_done(4, "t5");
    chk("t5_count", grants.size() - gbase, 4);
    for (int i = 0; i < 4; i++) chk("t5_order", grants[gbase + i], i);
    gbase = grants.size();
    set_req(0, 4, 4, 4'b0010);
    set_req(2, 6, 6, 4'b0010);
    wait_done(1, "t5b");
    chk("t5b_owner0", done_log, 4'b0001);
    wait_done(1, "t5c");
    chk("t5c_owner2", done_log, 4'b0100);
    chk("t5b_first", grants[gbase], 0);
    chk("t5b_second", grants[gbase + 1], 2);

    // Reset during WRITE
    nd0 = n_done;
    nw0 = n_we;
    set_req(1, 9, 9, 4'b0011);
    for (int i = 0; i < 20 && req_valid[1]; i++) tick();
    chk("t6_accepted", req_valid[1], 1'b0);
    repeat (2) tick();
    reset_i = 1'b1;
    set_req(0, 4, 4, 4'b0100);
    set_req(2, 6, 6, 4'b0100);
    tick();
    gbase = grants.size();
    reset_i = 1'b0;
    chk("t6_no_done", n_done - nd0, 0);
    chk("t6_no_we", n_we - nw0, 0);
    chk("t6_store", tile_mem[9][9], 7'h0F);
    wait_done(2, "t6");
    chk("t6_first_grant", grants[gbase], 0);

    tick();
    mism = 0;
    for (int y = 0; y < DIM; y++)
      for (int x = 0; x < DIM; x++)
        if (tile_mem[y][x] !== model_mem[y][x]) mism++;
    chk("store_vs_model", mism, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/map_hit_arbiter.md
# map_hit_arbiter

Serialises bullet-to-map damage requests from several bullet engines into the single read-modify-write port of the playfield tile store. Each request names a 13x13 tile and a corner mask. The arbiter reads the 7-bit tile word, clears the hit brick corners, optionally converts a fully destroyed brick to AIR, writes it back and reports the outcome to the requester. It sits between the bullet engines and the tile-store update port.

## Interface
Parameters:
- NUM_REQ, 4: number of bullet requesters (2..8).
- MAP_DIM, 13: tiles per row/column; valid coordinates are 0..MAP_DIM-1.

Ports:
- clk_i  in  1  system clock.
- reset_i  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid_i  in  NUM_REQ  per-requester request valid; held until accepted.
- req_x_i  in  4*NUM_REQ  packed tile column; requester k uses bits [4k+3:4k].
- req_y_i  in  4*NUM_REQ  packed tile row, same packing.
- req_mask_i  in  4*NUM_REQ  packed corner mask: bit0 UL, bit1 UR, bit2 LR, bit3 LL.
- req_ready_o  out  NUM_REQ  one-hot accept, combinational in IDLE; transfer when valid and ready are both high.
- done_o  out  NUM_REQ  one-hot, one-cycle completion pulse to the owning requester.
- result_o  out  2  outcome, valid with done_o: 00 no effect, 01 brick damaged, 10 brick destroyed, 11 hard block (WALL) absorbed.
- busy_o  out  1  high in every state except IDLE.
- map_x_o, map_y_o  out  4 each  tile address for both read and write.
- map_rd_data_i  in  7  tile word {type[6:4], state[3:0]}; registered read, valid one cycle after the address.
- map_we_o  out  1  one-cycle write strobe.
- map_wr_data_o  out  7  write word.

Block types: BRICK 000, WALL 001, TREE 010, WATER 011, AIR 111.

## Operation
- FSM states: IDLE, READ, EVAL, WRITE, DONE.
- **IDLE**
  - Round-robin grant among asserted req_valid_i. Search starts at last_grant+1 and wraps modulo NUM_REQ. After reset the pointer is 0, so requester 0 has highest priority.
  - On grant: pulse req_ready_o[k], and latch k, x, y and mask.
  - If the latched x or y is >= MAP_DIM: go to DONE with result 00, no read, no write.
  - Otherwise go to READ.
- **READ**: drive the map address; go to EVAL.
- **EVAL**: sample map_rd_data_i and compute hit = state & mask.
  - BRICK, hit == 0: result 00, no write, go to DONE.
  - BRICK, hit != 0: new = state & ~mask.
    - new != 0: result 01, write {BRICK,new}.
    - new == 0: result 10, write per Configuration.
    - Go to WRITE.
  - WALL: result 11, no write, go to DONE.
  - TREE, WATER, AIR and undefined types: result 00, no write, go to DONE.
- **WRITE**: map_we_o = 1 for exactly one cycle, with the address and data held; go to DONE.
- **DONE**: done_o[k] = 1 and result_o valid; go to IDLE.
- Address outputs hold the latched tile from READ through DONE and are 0 in IDLE.
- map_wr_data_o is 0 whenever map_we_o = 0.
- A request arriving while busy_o = 1 waits. Requesters must not change x/y/mask while valid is high and unaccepted.
- A requester whose valid drops before acceptance is simply skipped.

## Timing
- Request accepted at cycle T (IDLE): READ at T+1, EVAL at T+2, WRITE at T+3, DONE at T+4, IDLE at T+5.
- No-write path: DONE at T+3, IDLE at T+4. Out-of-range path: DONE at T+1, IDLE at T+2.
- Throughput: at most one request per 5 cycles; a new grant is possible in the cycle after DONE.
- Reset values: state IDLE, rr pointer 0, req_ready_o 0, done_o 0, result_o 00, busy_o 0, map_x_o/map_y_o 0, map_we_o 0, map_wr_data_o 0.
- Reset asserted mid-operation: the FSM returns to IDLE on the next edge. A pending WRITE is aborted (no strobe), no done_o is issued, and the latched request is discarded.
- Requests whose valid is held through reset are re-arbitrated from pointer 0.
- Two requests to the same tile are fully serialised: the second request reads the first request's written value.

## Configuration
- BRICK_TO_AIR_EN defined: a brick with all four corners cleared is written as {AIR,4'b1111}; result 10.
- BRICK_TO_AIR_EN undefined: the same brick is written as {BRICK,4'b0000}; result 10. A later hit on it gives hit == 0 and result 00.

## Test plan
- Single hit: req0 at x=3, y=2, mask 0001 on {BRICK,1111} -> ready at T; we at T+3 with {BRICK,1110}; done_o=0001 at T+4, result 01.
- Destroy: mask 1111 on {BRICK,0110} -> result 10. Written data is {AIR,1111} with BRICK_TO_AIR_EN defined and {BRICK,0000} without it.
- Wall and water: hit on {WALL,1111} -> result 11 at T+3, no we. Hit on {WATER,1111} -> result 00, no we.
- Round-robin: all four valid at reset -> grant order 0,1,2,3. Re-assert 0 and 2 -> grants 0 then 2; each done matches its owner.
- Out-of-range: x=13 -> done at T+1, result 00, no read address change, no we.
- Reset during WRITE: assert reset_i at T+3 -> map_we_o stays 0, no done_o, busy_o 0 next cycle, next grant goes to requester 0.
